// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit register-access SPI link: field widths,
// rw encoding and the master FSM state codes (also used by spi_slave users).
package spi_pkg;

  localparam int PKTSZ   = 16;
  localparam int ADDRSZ  = 7;
  localparam int PAYLOAD = 8;
  localparam int CLKDIV  = 4;

  localparam logic RW_READ = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SETUP = 3'd1;
  localparam state_t S_HIGH  = 3'd2;
  localparam state_t S_LOW   = 3'd3;
  localparam state_t S_HOLD  = 3'd4;
  localparam state_t S_GAP   = 3'd5;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer for the SPI master: tick marks the last clk cycle of each
// clkdiv-long SCLK phase, so every phase change also reloads the count.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int clkdiv = CLKDIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = (clkdiv > 1) ? $clog2(clkdiv) : 1;
  localparam logic [CW-1:0]  LAST = CW'(clkdiv - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets its default before any branch; a path that leaves a
  // combinational output unassigned infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

  // NOTE: state updates use <= so every flop samples pre-edge values;
  // blocking assignments here would create simulation order races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// CPOL=0/CPHA=0 SPI master for the {rw, addr, payload} register-access link;
// shifts MSB first and returns the read payload to the local requester.
module spi_master
  import spi_pkg::*;
#(
  parameter int pktsz   = PKTSZ,
  parameter int addrsz  = ADDRSZ,
  parameter int payload = PAYLOAD,
  parameter int clkdiv  = CLKDIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               rw,
  input  logic [addrsz-1:0]  addr,
  input  logic [payload-1:0] wr_d,
  output logic               busy,
  output logic               done,
  output logic [payload-1:0] rd_d,
  output logic               rd_dv,
  output logic               SCLK,
  output logic               SSB,
  output logic               MOSI,
  input  logic               MISO
);

  localparam int            BW       = $clog2(pktsz + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(pktsz);

  state_t             state_q, state_d;
  logic [pktsz-1:0]   tx_sr_q, tx_sr_d;
  logic [payload-1:0] rx_sr_q, rx_sr_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               rw_q, rw_d;
  logic               miso_s1_q, miso_s1_d, miso_s2_q, miso_s2_d;
  logic               sclk_q, sclk_d, ssb_q, ssb_d, mosi_q, mosi_d;
  logic               busy_q, busy_d, done_q, done_d, rd_dv_q, rd_dv_d;
  logic [payload-1:0] rd_d_q, rd_d_d;
  logic [payload-1:0] tx_payload;
  logic               tick;

  spi_clkgen #(.clkdiv(clkdiv)) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != S_IDLE),
    .clr   (state_q == S_IDLE),
    .tick  (tick)
  );

  // Reads clock out a zero payload so the slave never sees stale write data.
  assign tx_payload = (rw == RW_READ) ? {payload{1'b0}} : wr_d;

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    rw_d      = rw_q;
    rd_d_d    = rd_d_q;
    done_d    = 1'b0;
    rd_dv_d   = 1'b0;
    // MISO is asynchronous to clk; only the second stage is ever sampled.
    miso_s1_d = MISO;
    miso_s2_d = miso_s1_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SETUP;
          rw_d      = rw;
          bit_cnt_d = '0;
          tx_sr_d   = {rw, addr, tx_payload};
        end
      end
      S_SETUP: if (tick) state_d = S_HIGH;
      S_HIGH: begin
        if (tick) begin
          state_d   = S_LOW;
          rx_sr_d   = {rx_sr_q[payload-2:0], miso_s2_q};
          tx_sr_d   = {tx_sr_q[pktsz-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_LOW: if (tick) state_d = (bit_cnt_q == LAST_BIT) ? S_HOLD : S_HIGH;
      S_HOLD: if (tick) state_d = S_GAP;
      S_GAP: begin
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (rw_q == RW_READ) begin
            rd_dv_d = 1'b1;
            rd_d_d  = rx_sr_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are decoded from the next state so they stay aligned with the FSM.
    sclk_d = (state_d == S_HIGH);
    ssb_d  = !(state_d inside {S_SETUP, S_HIGH, S_LOW, S_HOLD});
    mosi_d = (state_d inside {S_SETUP, S_HIGH, S_LOW}) ? tx_sr_d[pktsz-1] : 1'b0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      rw_q      <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
      sclk_q    <= 1'b0;
      ssb_q     <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_dv_q   <= 1'b0;
      rd_d_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
      rw_q      <= rw_d;
      miso_s1_q <= miso_s1_d;
      miso_s2_q <= miso_s2_d;
      sclk_q    <= sclk_d;
      ssb_q     <= ssb_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_dv_q   <= rd_dv_d;
      rd_d_q    <= rd_d_d;
    end
  end

  assign SCLK  = sclk_q;
  assign SSB   = ssb_q;
  assign MOSI  = mosi_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rd_dv = rd_dv_q;
  assign rd_d  = rd_d_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a clkdiv=4 and a clkdiv=2 instance, each with an SPI
// slave model backed by a shared register file; scoreboard of expected results.
module tb_spi_master;

  localparam int NDUT = 2;
  localparam int DIV0 = 4;
  localparam int DIV1 = 2;
  localparam int MODE_NORMAL = 0;
  localparam int MODE_POKE   = 1;
  localparam int MODE_RESET  = 2;

  typedef struct {
    logic [15:0] mosi_word;
    logic [7:0]  rd_d;
    logic        rd_dv;
    int          latency;
  } exp_t;

  typedef struct {
    int         g;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wr_d;
    logic [7:0] slave_val;
    int         mode;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start [NDUT];
  logic       rw    [NDUT];
  logic [6:0] addr  [NDUT];
  logic [7:0] wr_d  [NDUT];
  logic       busy  [NDUT];
  logic       done  [NDUT];
  logic       rd_dv [NDUT];
  logic [7:0] rd_d  [NDUT];
  logic       sclk  [NDUT];
  logic       ssb   [NDUT];
  logic       mosi  [NDUT];
  logic [7:0] reg_file [128];

  exp_t       sb_q[$];
  logic [7:0] last_rd [NDUT];
  vec_t       vecs [8];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_inst
    localparam int DIV = (g == 0) ? DIV0 : DIV1;
    logic        miso_r   = 1'b0;
    logic        sclk_p   = 1'b0;
    logic        ssb_p    = 1'b1;
    logic [15:0] shift_in = '0;
    logic [15:0] frame    = '0;
    logic [7:0]  rd_val   = '0;
    int          idx      = 0;

    spi_master #(.pktsz(16), .addrsz(7), .payload(8), .clkdiv(DIV)) u_dut (
      .clk   (clk),
      .reset (reset),
      .start (start[g]),
      .rw    (rw[g]),
      .addr  (addr[g]),
      .wr_d  (wr_d[g]),
      .busy  (busy[g]),
      .done  (done[g]),
      .rd_d  (rd_d[g]),
      .rd_dv (rd_dv[g]),
      .SCLK  (sclk[g]),
      .SSB   (ssb[g]),
      .MOSI  (mosi[g]),
      .MISO  (miso_r)
    );

    // Mode-0 slave: samples MOSI on SCLK rise, shifts MISO after SCLK fall.
    // Header bits are driven high so they must not leak into rd_d.
    always @(negedge clk) begin
      if (ssb_p && !ssb[g]) begin
        idx      = 0;
        shift_in = '0;
        miso_r   = 1'b1;
      end
      if (!ssb[g] && !sclk_p && sclk[g]) shift_in = {shift_in[14:0], mosi[g]};
      if (!ssb[g] && sclk_p && !sclk[g]) begin
        idx++;
        if (idx == 8) rd_val = reg_file[shift_in[6:0]];
        miso_r = (idx < 8) ? 1'b1 : ((idx < 16) ? rd_val[15-idx] : 1'b0);
      end
      if (!ssb_p && ssb[g]) frame = shift_in;
      sclk_p = sclk[g];
      ssb_p  = ssb[g];
    end
  end

  function automatic logic [15:0] frame_of(input int g);
    return (g == 0) ? gen_inst[0].frame : gen_inst[1].frame;
  endfunction

  function automatic int div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic quiet(input int g, input int cycles, input string name);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done[g] || busy[g] || !ssb[g]) bad++;
    end
    check(name, bad, 0);
  endtask

  // Runs one transaction from a negedge; returns at a negedge.
  task automatic txn(input int g, input logic t_rw, input logic [6:0] t_addr,
                     input logic [7:0] t_wr, input int mode);
    exp_t e;
    int   n = 0;
    int   rises = 0;
    int   busy_gaps = 0;
    logic sclk_prev = 1'b0;
    bit   seen_done = 1'b0;
    int   div = div_of(g);
    int   poke_at  = 1 + div + 2 * div * 7 + div / 2;
    int   reset_at = 1 + div + 2 * div * 5 + div / 2;

    e.mosi_word = {t_rw, t_addr, t_rw ? 8'h00 : t_wr};
    e.rd_dv     = t_rw;
    e.rd_d      = t_rw ? reg_file[t_addr] : last_rd[g];
    e.latency   = 1 + div * (2 * 16 + 3);
    sb_q.push_back(e);

    rw[g] = t_rw; addr[g] = t_addr; wr_d[g] = t_wr; start[g] = 1'b1;
    while (!seen_done && n < e.latency + 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start[g] = (mode == MODE_POKE && n == poke_at);
      if (sclk[g] && !sclk_prev) rises++;
      sclk_prev = sclk[g];
      if (done[g]) seen_done = 1'b1;
      else if (!busy[g]) busy_gaps++;
      if (mode == MODE_RESET && n == reset_at) begin
        reset = 1'b1;
        #1;
        check("reset_mid_pins", {ssb[g], sclk[g], mosi[g], busy[g]}, 4'b1000);
        check("reset_mid_outputs", {done[g], rd_dv[g], rd_d[g]}, 10'h000);
        void'(sb_q.pop_front());
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        quiet(g, 50, "reset_no_done");
        return;
      end
    end

    e = sb_q.pop_front();
    check("latency", n, e.latency);
    check("mosi_word", frame_of(g), e.mosi_word);
    check("rd_dv_with_done", rd_dv[g], e.rd_dv);
    check("rd_d", rd_d[g], e.rd_d);
    check("sclk_pulses", rises, 16);
    check("busy_gaps", busy_gaps, 0);
    check("busy_at_done", busy[g], 1'b0);
    last_rd[g] = e.rd_d;
    @(negedge clk);
    check("done_single_pulse", {done[g], rd_dv[g]}, 2'b00);
    check("rd_d_hold", rd_d[g], e.rd_d);
    quiet(g, 3 * div, "no_requeue");
  endtask

  initial begin
    exp_t e;
    int   n, ndone, run, gap_run, lat0;
    bit   after_done;

    reset = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      start[g] = 1'b0; rw[g] = 1'b0; addr[g] = '0; wr_d[g] = '0; last_rd[g] = 8'h00;
    end
    for (int i = 0; i < 128; i++) reg_file[i] = 8'(i * 3 + 1);

    vecs[0] = '{0, 1'b0, 7'h15, 8'h2A, 8'h00, MODE_NORMAL};
    vecs[1] = '{0, 1'b1, 7'h05, 8'hEE, 8'hC3, MODE_NORMAL};
    vecs[2] = '{0, 1'b0, 7'h40, 8'h81, 8'h00, MODE_NORMAL};
    vecs[3] = '{0, 1'b0, 7'h0A, 8'h55, 8'h00, MODE_POKE};
    vecs[4] = '{0, 1'b1, 7'h2B, 8'h00, 8'h3C, MODE_RESET};
    vecs[5] = '{0, 1'b1, 7'h2B, 8'h00, 8'h3C, MODE_NORMAL};
    vecs[6] = '{1, 1'b1, 7'h7F, 8'h00, 8'hFF, MODE_NORMAL};
    vecs[7] = '{1, 1'b1, 7'h7F, 8'h00, 8'h00, MODE_NORMAL};

    repeat (2) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("reset_state", {ssb[g], sclk[g], mosi[g], busy[g], done[g], rd_dv[g], rd_d[g]},
            {6'b100000, 8'h00});
    end
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      reg_file[vecs[i].addr] = vecs[i].slave_val;
      txn(vecs[i].g, vecs[i].rw, vecs[i].addr, vecs[i].wr_d, vecs[i].mode);
    end

    // start held high: each done cycle accepts the next packet, so SSB stays
    // high for the GAP phase plus that done/accept cycle.
    lat0 = 1 + DIV0 * 35;
    e.mosi_word = {1'b0, 7'h33, 8'h5A};
    e.rd_d      = last_rd[0];
    e.rd_dv     = 1'b0;
    e.latency   = lat0;
    sb_q.push_back(e);
    sb_q.push_back(e);
    rw[0] = 1'b0; addr[0] = 7'h33; wr_d[0] = 8'h5A; start[0] = 1'b1;
    n = 0; ndone = 0; run = 0; gap_run = 0; after_done = 1'b0;
    while (ndone < 2 && n < 2 * lat0 + 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (after_done) begin
        check("b2b_reaccept_busy", busy[0], 1'b1);
        after_done = 1'b0;
      end
      if (ssb[0]) run++;
      else begin
        if (ndone == 1 && gap_run == 0) gap_run = run;
        run = 0;
      end
      if (done[0]) begin
        ndone++;
        e = sb_q.pop_front();
        check("b2b_latency", n, ndone * e.latency);
        check("b2b_mosi_word", frame_of(0), e.mosi_word);
        check("b2b_rd", {rd_dv[0], rd_d[0]}, {e.rd_dv, e.rd_d});
        if (ndone == 1) after_done = 1'b1;
        else start[0] = 1'b0;
      end
    end
    check("b2b_done_count", ndone, 2);
    check("b2b_ssb_gap", gap_run, DIV0 + 1);
    quiet(0, 20, "b2b_stop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
